// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, digit type and the nibble sanitiser
// used by the counter load path and the 7-segment decoders.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Non-decimal nibbles (A-F) collapse to zero so Q always holds valid BCD.
    function automatic bcd_t bcd_sanitize(input bcd_t n);
        return (n > BCD_MAX) ? bcd_t'(0) : n;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle of the multi-digit BCD up/down counter.
interface bcd_updown_counter_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  En;
    logic                  Up;
    logic                  Sat_mode;
    logic                  Load;
    logic [4*DIGITS-1:0]   Load_val;
    logic [4*DIGITS-1:0]   Q;
    logic                  Tc;
    logic                  Wrap;
    logic                  Ovf;

    modport master (
        output En, Up, Sat_mode, Load, Load_val,
        input  Q, Tc, Wrap, Ovf
    );

    modport slave (
        input  En, Up, Sat_mode, Load, Load_val,
        output Q, Tc, Wrap, Ovf
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD decade: load with sanitising, or step up/down with 9<->0 roll.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic up,
    input  logic load,
    input  bcd_t load_d,
    output bcd_t d,
    output logic is_max,
    output logic is_min
);

    assign is_max = (d == BCD_MAX);
    assign is_min = (d == bcd_t'(0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d <= bcd_t'(0);
        end else if (load) begin
            d <= bcd_sanitize(load_d);
        end else if (step) begin
            if (up) begin
                d <= is_max ? bcd_t'(0) : d + bcd_t'(1);
            end else begin
                d <= is_min ? BCD_MAX : d - bcd_t'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Synchronous DIGITS-decade BCD up/down counter with load, wrap/saturate
// mode, combinational terminal count and registered Wrap/Ovf flags.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned SAT_DEFAULT = 0
) (
    input  logic                  Clo,
    input  logic                  Clr,
    bcd_updown_counter_if.slave   bus
);

    if (DIGITS == 0) begin : g_bad_digits
        $error("bcd_updown_counter: DIGITS must be at least 1");
    end
    if (SAT_DEFAULT > 1) begin : g_bad_sat
        $error("bcd_updown_counter: SAT_DEFAULT must be 0 or 1");
    end

    logic [DIGITS-1:0] is_max;
    logic [DIGITS-1:0] is_min;
    logic [DIGITS-1:0] dig_step;
    logic [DIGITS:0]   chain;
    bcd_t              dig_q [DIGITS];
    logic              tc;
    logic              sat_hold;
    logic              step_g;
    logic              wrap_q;
    logic              ovf_q;

    // chain[i]: every digit below i sits at its end value for the current direction.
    always_comb begin
        chain    = '0;
        chain[0] = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            chain[i+1] = chain[i] & (bus.Up ? is_max[i] : is_min[i]);
        end
    end

    assign tc       = chain[DIGITS];
    assign sat_hold = tc & bus.Sat_mode;
    assign step_g   = bus.En & ~bus.Load & ~sat_hold;
    assign dig_step = {DIGITS{step_g}} & chain[DIGITS-1:0];

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (Clo),
            .rst    (Clr),
            .step   (dig_step[g]),
            .up     (bus.Up),
            .load   (bus.Load),
            .load_d (bus.Load_val[g*BCD_W +: BCD_W]),
            .d      (dig_q[g]),
            .is_max (is_max[g]),
            .is_min (is_min[g])
        );
        assign bus.Q[g*BCD_W +: BCD_W] = dig_q[g];
    end

    // Wrap pulses for one cycle after a wrap-around; Ovf is sticky until Load/Clr.
    always_ff @(posedge Clo or posedge Clr) begin
        if (Clr) begin
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (bus.Load) begin
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (bus.En && tc) begin
            wrap_q <= ~bus.Sat_mode;
            ovf_q  <= 1'b1;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign bus.Tc   = tc;
    assign bus.Wrap = wrap_q;
    assign bus.Ovf  = ovf_q;

endmodule
